// File: rtl/chess_turn_controller.sv
`default_nettype none
// ============================================================================
// Module   : chess_turn_controller
// Purpose  : Turn sequencer driving the run flags of the white and black
//            countdown timers. Optional macro TURN_BUTTON_SYNC_EN adds
//            button synchronizers and edge detectors on start/move/pause.
// Revision : 1.0 - initial release
// ============================================================================
module chess_turn_controller #(
   parameter int MOVE_CNT_WIDTH = 9,
   parameter int GUARD_CYCLES   = 4
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      move_done,
   input  logic                      pause_req,
   input  logic                      white_timeout,
   input  logic                      black_timeout,
   output logic                      white_flag,
   output logic                      black_flag,
   output logic                      turn,
   output logic                      paused,
   output logic                      game_over,
   output logic                      winner,
   output logic                      new_game,
   output logic [MOVE_CNT_WIDTH-1:0] move_count
);

   localparam logic [7:0] GUARD_LOAD = 8'(GUARD_CYCLES);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WHITE_RUN = 3'd1,
      BLACK_RUN = 3'd2,
      PAUSED    = 3'd3,
      GAME_OVER = 3'd4
   } state_t;

   state_t                    state;
   state_t                    state_nxt;
   logic                      turn_nxt;
   logic                      winner_nxt;
   logic                      new_game_nxt;
   logic [MOVE_CNT_WIDTH-1:0] move_count_nxt;
   logic [7:0]                guard;
   logic [7:0]                guard_nxt;
   logic                      own_timeout;

   logic                      start_ev;
   logic                      move_ev;
   logic                      pause_ev;

`ifdef TURN_BUTTON_SYNC_EN
   // Two synchronizer stages plus one history stage for rising-edge detection.
   logic [2:0] sync_a;
   logic [2:0] sync_b;
   logic [2:0] sync_c;

   always_ff @(posedge clock) begin
      if (reset) begin
         sync_a <= 3'b000;
         sync_b <= 3'b000;
         sync_c <= 3'b000;
      end else begin
         sync_a <= {start, move_done, pause_req};
         sync_b <= sync_a;
         sync_c <= sync_b;
      end
   end

   assign {start_ev, move_ev, pause_ev} = sync_b & ~sync_c;
`else
   assign {start_ev, move_ev, pause_ev} = {start, move_done, pause_req};
`endif

   always_comb begin
      state_nxt      = state;
      turn_nxt       = turn;
      winner_nxt     = winner;
      new_game_nxt   = 1'b0;
      move_count_nxt = move_count;
      guard_nxt      = guard;
      own_timeout    = (state == WHITE_RUN) ? white_timeout : black_timeout;

      case (state)
         IDLE: begin
            if (start_ev) begin
               state_nxt    = WHITE_RUN;
               new_game_nxt = 1'b1;
               turn_nxt     = 1'b0;
               guard_nxt    = GUARD_LOAD;
            end
         end
         WHITE_RUN, BLACK_RUN: begin
            if (guard != 8'd0) begin
               guard_nxt = guard - 8'd1;
            end
            // The side whose clock runs out loses.
            if (own_timeout) begin
               state_nxt  = GAME_OVER;
               winner_nxt = (state == WHITE_RUN);
            end else if (pause_ev) begin
               state_nxt = PAUSED;
            end else if (move_ev && (guard == 8'd0)) begin
               state_nxt = (state == WHITE_RUN) ? BLACK_RUN : WHITE_RUN;
               turn_nxt  = (state == WHITE_RUN);
               guard_nxt = GUARD_LOAD;
               if (move_count != {MOVE_CNT_WIDTH{1'b1}}) begin
                  move_count_nxt = move_count + 1'b1;
               end
            end
         end
         PAUSED: begin
            if (pause_ev) begin
               state_nxt = turn ? BLACK_RUN : WHITE_RUN;
            end
         end
         GAME_OVER: begin
            if (start_ev) begin
               state_nxt      = IDLE;
               move_count_nxt = '0;
               new_game_nxt   = 1'b1;
               winner_nxt     = 1'b0;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Flags are registered from the next state, so they always equal a decode
   // of the state register with no added latency.
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         white_flag <= 1'b0;
         black_flag <= 1'b0;
         paused     <= 1'b0;
         game_over  <= 1'b0;
         turn       <= 1'b0;
         winner     <= 1'b0;
         new_game   <= 1'b0;
         move_count <= '0;
         guard      <= 8'd0;
      end else begin
         state      <= state_nxt;
         white_flag <= (state_nxt == WHITE_RUN);
         black_flag <= (state_nxt == BLACK_RUN);
         paused     <= (state_nxt == PAUSED);
         game_over  <= (state_nxt == GAME_OVER);
         turn       <= turn_nxt;
         winner     <= winner_nxt;
         new_game   <= new_game_nxt;
         move_count <= move_count_nxt;
         guard      <= guard_nxt;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_chess_turn_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_chess_turn_controller
// Purpose  : Scoreboard bench for chess_turn_controller (default build).
// Revision : 1.0 - initial release
// ============================================================================
module tb_chess_turn_controller;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       move_done = 1'b0;
   logic       pause_req = 1'b0;
   logic       white_timeout = 1'b0;
   logic       black_timeout = 1'b0;
   logic       white_flag;
   logic       black_flag;
   logic       turn;
   logic       paused;
   logic       game_over;
   logic       winner;
   logic       new_game;
   logic [8:0] move_count;

   chess_turn_controller #(
      .MOVE_CNT_WIDTH(9),
      .GUARD_CYCLES  (4)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .start        (start),
      .move_done    (move_done),
      .pause_req    (pause_req),
      .white_timeout(white_timeout),
      .black_timeout(black_timeout),
      .white_flag   (white_flag),
      .black_flag   (black_flag),
      .turn         (turn),
      .paused       (paused),
      .game_over    (game_over),
      .winner       (winner),
      .new_game     (new_game),
      .move_count   (move_count)
   );

   always #5 clock = ~clock;

   typedef struct {
      int         cyc;
      string      name;
      logic [6:0] flags;  // {white_flag, black_flag, turn, paused, game_over, winner, new_game}
      logic [8:0] mc;
   } exp_t;

   exp_t exp_q[$];
   int   cyc = 0;
   int   n_compared = 0;
   int   n_mismatched = 0;
   bit   stim_done = 1'b0;

   always @(posedge clock) cyc <= cyc + 1;

   // Monitor: at each falling edge, compare every expectation tagged for this cycle.
   initial begin
      exp_t       e;
      logic [6:0] act;
      forever begin
         @(negedge clock);
         act = {white_flag, black_flag, turn, paused, game_over, winner, new_game};
         while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            n_compared++;
            if (e.cyc != cyc) begin
               n_mismatched++;
               $display("FAIL %s: expectation for cycle %0d checked late at cycle %0d", e.name, e.cyc, cyc);
            end else if (act !== e.flags || move_count !== e.mc) begin
               n_mismatched++;
               $display("FAIL %s: got wf,bf,turn,pa,go,win,ng=%b mc=%0d, need %b mc=%0d",
                        e.name, act, move_count, e.flags, e.mc);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic expect_now(input string nm, input logic [6:0] fl, input logic [8:0] mc);
      exp_t e;
      e.cyc   = cyc;
      e.name  = nm;
      e.flags = fl;
      e.mc    = mc;
      exp_q.push_back(e);
   endtask

   task automatic pulse_start();
      start = 1'b1; tick(); start = 1'b0;
   endtask

   task automatic pulse_move();
      move_done = 1'b1; tick(); move_done = 1'b0;
   endtask

   task automatic pulse_pause();
      pause_req = 1'b1; tick(); pause_req = 1'b0;
   endtask

   //                             wf bf tn pa go wn ng
   localparam logic [6:0] F_ZERO  = 7'b0_0_0_0_0_0_0;
   localparam logic [6:0] F_WNEW  = 7'b1_0_0_0_0_0_1;
   localparam logic [6:0] F_WRUN  = 7'b1_0_0_0_0_0_0;
   localparam logic [6:0] F_BRUN  = 7'b0_1_1_0_0_0_0;
   localparam logic [6:0] F_BPAU  = 7'b0_0_1_1_0_0_0;
   localparam logic [6:0] F_GOW1  = 7'b0_0_0_0_1_1_0;
   localparam logic [6:0] F_INEW  = 7'b0_0_0_0_0_0_1;
   localparam logic [6:0] F_GOB0  = 7'b0_0_1_0_1_0_0;

   initial begin
      idle(3);
      expect_now("reset_held", F_ZERO, 9'd0);
      reset = 1'b0;
      idle(2);
      expect_now("idle_after_reset", F_ZERO, 9'd0);

      pulse_start();
      expect_now("start_to_white", F_WNEW, 9'd0);
      tick();
      expect_now("new_game_one_cycle", F_WRUN, 9'd0);
      idle(8);
      pulse_move();
      expect_now("first_move", F_BRUN, 9'd1);
      tick();
      pulse_move();
      expect_now("guarded_move_dropped", F_BRUN, 9'd1);

      pulse_pause();
      expect_now("pause_black", F_BPAU, 9'd1);
      pulse_move();
      expect_now("move_in_pause", F_BPAU, 9'd1);
      pulse_pause();
      expect_now("resume_black", F_BRUN, 9'd1);
      idle(6);
      pulse_move();
      expect_now("second_move", F_WRUN, 9'd2);
      idle(6);

      white_timeout = 1'b1; move_done = 1'b1;
      tick();
      white_timeout = 1'b0; move_done = 1'b0;
      expect_now("white_timeout_beats_move", F_GOW1, 9'd2);
      pulse_move();
      pulse_pause();
      expect_now("game_over_holds", F_GOW1, 9'd2);
      pulse_start();
      expect_now("clear_to_idle", F_INEW, 9'd0);
      tick();
      expect_now("idle_after_clear", F_ZERO, 9'd0);

      pulse_start();
      expect_now("restart", F_WNEW, 9'd0);
      idle(6);
      black_timeout = 1'b1;
      idle(2);
      expect_now("black_timeout_ignored_white", F_WRUN, 9'd0);
      pulse_move();
      expect_now("enter_black_with_timeout", F_BRUN, 9'd1);
      tick();
      black_timeout = 1'b0;
      expect_now("black_loses_first_cycle", F_GOB0, 9'd1);

      pulse_start();
      pulse_start();
      expect_now("third_game", F_WNEW, 9'd0);
      for (int i = 0; i < 5; i++) begin
         idle(5);
         pulse_move();
      end
      expect_now("five_moves", F_BRUN, 9'd5);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      expect_now("mid_game_reset", F_ZERO, 9'd0);

      pulse_start();
      for (int i = 0; i < 511; i++) begin
         idle(5);
         pulse_move();
      end
      expect_now("count_511", F_BRUN, 9'd511);
      for (int i = 0; i < 3; i++) begin
         idle(5);
         pulse_move();
      end
      expect_now("count_saturated", F_WRUN, 9'd511);

      idle(3);
      stim_done = 1'b1;
   end

   initial begin
      int budget;
      budget = 0;
      while (!stim_done && budget < 20000) begin
         @(posedge clock);
         budget++;
      end
      if (!stim_done) begin
         n_mismatched++;
         $display("FAIL watchdog: stimulus did not finish within %0d cycles", budget);
      end
      repeat (3) @(posedge clock);
      while (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         n_compared++;
         n_mismatched++;
         $display("FAIL %s: expectation never checked (cycle %0d)", e.name, e.cyc);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/chess_turn_controller.md
Name: chess_turn_controller

Overview:
- Upstream sequencer for the two per-player countdown timers in the timed chess game.
- Converts start, move-complete, pause and timeout events into the run `flag` for the white and black countdown timers.
- Tracks whose turn it is, counts moves and declares the winner on timeout.
- Outputs drive the `flag` input of each countdown timer instance directly; each timer's `Timeout` output feeds back in.

Parameters:
- MOVE_CNT_WIDTH, 9: width of the move counter; the counter saturates at 2^MOVE_CNT_WIDTH-1.
- GUARD_CYCLES, 4: number of cycles after a turn change during which move_done is ignored (double-press guard). Legal range is 1..255.

Ports:
- clock  in  1  system clock (50 MHz).
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse: begin game (from IDLE) or clear a finished game (from GAME_OVER).
- move_done  in  1  single-cycle pulse: the current player has completed a move.
- pause_req  in  1  single-cycle pulse: toggle pause.
- white_timeout  in  1  Timeout from the white countdown timer (level).
- black_timeout  in  1  Timeout from the black countdown timer (level).
- white_flag  out  1  run enable to the white timer.
- black_flag  out  1  run enable to the black timer.
- turn  out  1  side to move: 0 = white, 1 = black.
- paused  out  1  high while in PAUSED.
- game_over  out  1  high while in GAME_OVER.
- winner  out  1  valid when game_over is high: 0 = white won, 1 = black won.
- new_game  out  1  one-cycle pulse to reset both timers.
- move_count  out  MOVE_CNT_WIDTH  number of completed moves.

Behaviour:
- Clocking and reset:
  - All state changes on the rising edge of clock.
  - Reset is synchronous and active-high and overrides every other input.
- Reset values:
  - State = IDLE.
  - white_flag = black_flag = 0, turn = 0, paused = 0, game_over = 0, winner = 0, new_game = 0, move_count = 0.
  - Guard counter = 0.
- States: IDLE, WHITE_RUN, BLACK_RUN, PAUSED, GAME_OVER.
- Moore outputs, decoded from the state register (no extra latency):
  - white_flag = (state == WHITE_RUN).
  - black_flag = (state == BLACK_RUN).
  - paused = (state == PAUSED).
  - game_over = (state == GAME_OVER).
- Event priority within a cycle, highest first: reset > own-timeout > pause_req > move_done.
- IDLE:
  - start=1 -> WHITE_RUN at that edge; new_game pulses high for exactly that one cycle; turn = 0; guard counter loads GUARD_CYCLES.
  - All other inputs are ignored.
- WHITE_RUN:
  - white_timeout=1 -> GAME_OVER, winner = 1.
  - Else pause_req=1 -> PAUSED.
  - Else move_done=1 with guard counter == 0 -> BLACK_RUN; turn = 1; move_count increments (saturating); guard counter loads GUARD_CYCLES.
  - move_done while the guard counter is nonzero is dropped.
  - black_timeout is ignored.
- BLACK_RUN: mirror of WHITE_RUN.
  - black_timeout=1 -> GAME_OVER, winner = 0.
  - A move goes to WHITE_RUN with turn = 0.
- Guard counter:
  - Decrements by 1 per cycle while nonzero in WHITE_RUN or BLACK_RUN.
  - Holds its value in PAUSED.
- PAUSED:
  - pause_req=1 -> WHITE_RUN if turn == 0, BLACK_RUN if turn == 1.
  - move_done, start and both timeouts are ignored.
  - turn and move_count are held.
- GAME_OVER:
  - Both flags are 0; winner and move_count are held.
  - start=1 -> IDLE, move_count cleared, new_game pulses for one cycle, winner cleared.
  - All other inputs are ignored.
- start outside IDLE and GAME_OVER is ignored.
- A timeout that is already high when a turn begins is acted on in the first cycle of that turn.
- move_count saturates and does not wrap.

Optional Feature:
- Macro: TURN_BUTTON_SYNC_EN.
- Defined:
  - start, move_done and pause_req are treated as raw asynchronous button levels.
  - Each passes through a 2-flop synchronizer, then a rising-edge detector.
  - Each event is therefore internally one pulse per press, 3 cycles after the input rises.
  - Synchronizer flops reset to 0.
- Undefined:
  - The inputs are used directly as synchronous single-cycle pulses.
  - Zero added latency.

Test Plan:
- Reset, then start pulse -> next cycle: white_flag=1, black_flag=0, turn=0, new_game high for 1 cycle, move_count=0.
- In WHITE_RUN, move_done 10 cycles after start -> next cycle: black_flag=1, white_flag=0, turn=1, move_count=1. A second move_done 2 cycles later (GUARD_CYCLES=4) -> ignored, move_count stays 1.
- In BLACK_RUN, pause_req -> both flags 0, paused=1. move_done during pause -> no change. Second pause_req -> black_flag=1, turn=1.
- In WHITE_RUN, assert white_timeout and move_done in the same cycle -> GAME_OVER, game_over=1, winner=1, move_count unchanged. Then start -> IDLE, move_count=0, new_game pulse.
- Assert black_timeout while in WHITE_RUN -> ignored. Then change turn -> GAME_OVER on the first BLACK_RUN cycle, winner=0.
- Apply reset mid-BLACK_RUN with move_count=5 -> next cycle all outputs at reset values. Run 2^MOVE_CNT_WIDTH+2 moves -> move_count saturates at 511.
